// File: rtl/core_run_controller_pkg.sv
// Shared definitions for the core run/halt sequencer: run-state encodings and halt-cause codes.
package core_run_controller_pkg;

    localparam int CNT_W_DEFAULT  = 32;
    localparam int STEP_W_DEFAULT = 8;

    typedef enum logic [1:0] {
        RUN_IDLE   = 2'd0,
        RUN_RUN    = 2'd1,
        RUN_STEP   = 2'd2,
        RUN_HALTED = 2'd3
    } run_state_t;

    typedef enum logic [2:0] {
        HALT_CAUSE_NONE  = 3'd0,
        HALT_CAUSE_HOST  = 3'd1,
        HALT_CAUSE_CORE  = 3'd2,
        HALT_CAUSE_LIMIT = 3'd3,
        HALT_CAUSE_STEP  = 3'd4
    } halt_cause_t;

    function automatic logic state_is_active(input run_state_t s);
        return (s == RUN_RUN) || (s == RUN_STEP);
    endfunction

endpackage

// File: rtl/core_run_controller_run_cycle_counter.sv
// Saturating enabled-cycle counter with clear/increment; with CYCLE_LIMIT_EN it also flags
// the last cycle before the watchdog budget is reached.
module run_cycle_counter
    import core_run_controller_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEFAULT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_clear,
    input  logic             i_inc,
    output logic [CNT_W-1:0] o_count
`ifdef CYCLE_LIMIT_EN
    ,
    input  logic [CNT_W-1:0] i_limit,
    output logic             o_limit_hit
`endif
);

    logic [CNT_W-1:0] r_count;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_inc && (r_count != '1)) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_count = r_count;

`ifdef CYCLE_LIMIT_EN
    // count+1 == limit, written so a saturated count can never match
    assign o_limit_hit = (i_limit != '0) && (r_count == (i_limit - 1'b1));
`endif

endmodule

// File: rtl/core_run_controller.sv
// Run/halt sequencer producing the core clock enable from host and core requests.
// Optional watchdog halt is built when CYCLE_LIMIT_EN is defined.
module core_run_controller
    import core_run_controller_pkg::*;
#(
    parameter int CNT_W  = CNT_W_DEFAULT,
    parameter int STEP_W = STEP_W_DEFAULT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start_req,
    input  logic              halt_req,
    input  logic              step_req,
    input  logic [STEP_W-1:0] step_count,
    input  logic              core_halt,
`ifdef CYCLE_LIMIT_EN
    input  logic [CNT_W-1:0]  cycle_limit,
`endif
    output logic              core_clk_en,
    output logic              running,
    output logic              halted,
    output logic [2:0]        halt_cause,
    output logic [CNT_W-1:0]  cycle_count,
    output logic              done_pulse
);

    run_state_t        r_state;
    halt_cause_t       r_cause;
    logic              r_run_en;
    logic              r_halted;
    logic              r_done;
    logic [STEP_W-1:0] r_step_left;

    run_state_t        w_next_state;
    halt_cause_t       w_next_cause;
    logic              w_clear;
    logic              w_load_step;
    logic              w_step_ok;
    logic [CNT_W-1:0]  w_count;
`ifdef CYCLE_LIMIT_EN
    logic              w_limit_hit;
`endif

    run_cycle_counter #(.CNT_W(CNT_W)) u_counter (
        .clk         (clk),
        .reset       (reset),
        .i_clear     (w_clear),
        .i_inc       (r_run_en),
        .o_count     (w_count)
`ifdef CYCLE_LIMIT_EN
        ,
        .i_limit     (cycle_limit),
        .o_limit_hit (w_limit_hit)
`endif
    );

    assign w_step_ok = step_req && (step_count != '0);

    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    always_comb begin
        w_next_state = r_state;
        w_next_cause = r_cause;
        w_clear      = 1'b0;
        w_load_step  = 1'b0;
        case (r_state)
            RUN_IDLE: begin
                if (start_req) begin
                    w_next_state = RUN_RUN;
                    w_clear      = 1'b1;
                end else if (w_step_ok) begin
                    w_next_state = RUN_STEP;
                    w_load_step  = 1'b1;
                end
            end
            RUN_RUN: begin
                if (core_halt) begin
                    w_next_state = RUN_HALTED;
                    w_next_cause = HALT_CAUSE_CORE;
                end else if (halt_req) begin
                    w_next_state = RUN_HALTED;
                    w_next_cause = HALT_CAUSE_HOST;
`ifdef CYCLE_LIMIT_EN
                end else if (w_limit_hit) begin
                    w_next_state = RUN_HALTED;
                    w_next_cause = HALT_CAUSE_LIMIT;
`endif
                end
            end
            RUN_STEP: begin
                if (core_halt) begin
                    w_next_state = RUN_HALTED;
                    w_next_cause = HALT_CAUSE_CORE;
                end else if (halt_req) begin
                    w_next_state = RUN_HALTED;
                    w_next_cause = HALT_CAUSE_HOST;
                end else if (r_step_left == STEP_W'(1)) begin
                    w_next_state = RUN_HALTED;
                    w_next_cause = HALT_CAUSE_STEP;
                end else if (start_req) begin
                    w_next_state = RUN_RUN;
                end
            end
            RUN_HALTED: begin
                if (start_req) begin
                    w_next_state = RUN_RUN;
                    w_next_cause = HALT_CAUSE_NONE;
                end else if (w_step_ok) begin
                    w_next_state = RUN_STEP;
                    w_next_cause = HALT_CAUSE_NONE;
                    w_load_step  = 1'b1;
                end
            end
            default: begin
                w_next_state = RUN_IDLE;
                w_next_cause = HALT_CAUSE_NONE;
            end
        endcase
    end

    // Outputs are registered from the next state so they switch on the same edge as the state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= RUN_IDLE;
            r_cause     <= HALT_CAUSE_NONE;
            r_run_en    <= 1'b0;
            r_halted    <= 1'b0;
            r_done      <= 1'b0;
            r_step_left <= '0;
        end else begin
            r_state  <= w_next_state;
            r_cause  <= w_next_cause;
            r_run_en <= state_is_active(w_next_state);
            r_halted <= (w_next_state == RUN_HALTED);
            r_done   <= (w_next_state == RUN_HALTED) && (r_state != RUN_HALTED);
            if (w_load_step) begin
                r_step_left <= step_count;
            end else if (w_next_state == RUN_STEP) begin
                r_step_left <= r_step_left - 1'b1;
            end else begin
                r_step_left <= '0;
            end
        end
    end

    assign core_clk_en = r_run_en;
    assign running     = r_run_en;
    assign halted      = r_halted;
    assign halt_cause  = r_cause;
    assign cycle_count = w_count;
    assign done_pulse  = r_done;

endmodule

// File: tb/tb_core_run_controller.sv
// Self-checking bench for core_run_controller: directed scenarios plus randomized requests
// against a behavioural model; watchdog scenarios are built when CYCLE_LIMIT_EN is defined.
module tb_core_run_controller;

    logic        clk;
    logic        reset;
    logic        start_req;
    logic        halt_req;
    logic        step_req;
    logic [7:0]  step_count;
    logic        core_halt;
    logic [31:0] lim_val;

    logic        core_clk_en, running, halted, done_pulse;
    logic [2:0]  halt_cause;
    logic [31:0] cycle_count;

    logic        s_clk_en, s_running, s_halted, s_done;
    logic [2:0]  s_cause;
    logic [3:0]  s_count;

    int n_checks = 0;
    int n_fail   = 0;

    // Model: run flag, remaining step budget (0 = continuous), unbounded enabled-cycle count.
    bit     m_run, m_halt, m_done, small_sync;
    int     m_budget, m_cause;
    longint m_count;

    core_run_controller #(.CNT_W(32), .STEP_W(8)) dut (
        .clk(clk), .reset(reset), .start_req(start_req), .halt_req(halt_req),
        .step_req(step_req), .step_count(step_count), .core_halt(core_halt),
`ifdef CYCLE_LIMIT_EN
        .cycle_limit(lim_val),
`endif
        .core_clk_en(core_clk_en), .running(running), .halted(halted),
        .halt_cause(halt_cause), .cycle_count(cycle_count), .done_pulse(done_pulse)
    );

    core_run_controller #(.CNT_W(4), .STEP_W(8)) dut_small (
        .clk(clk), .reset(reset), .start_req(start_req), .halt_req(halt_req),
        .step_req(step_req), .step_count(step_count), .core_halt(core_halt),
`ifdef CYCLE_LIMIT_EN
        .cycle_limit(4'd0),
`endif
        .core_clk_en(s_clk_en), .running(s_running), .halted(s_halted),
        .halt_cause(s_cause), .cycle_count(s_count), .done_pulse(s_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic longint sat(input longint v, input int w);
        longint cap;
        cap = (longint'(1) << w) - 1;
        return (v > cap) ? cap : v;
    endfunction

    task automatic model_reset();
        m_run = 0; m_halt = 0; m_done = 0; m_budget = 0; m_cause = 0; m_count = 0;
        small_sync = 1;
    endtask

    task automatic enter_halt(input int cause);
        m_run = 0; m_halt = 1; m_cause = cause; m_done = 1; m_budget = 0;
    endtask

    task automatic model_edge(input bit s, input bit h, input bit st, input int sc, input bit ch);
        longint old;
        old    = m_count;
        m_done = 0;
        if (m_run) begin
            m_count++;
            if (ch) enter_halt(2);
            else if (h) enter_halt(1);
            else if (m_budget == 0 && lim_val != 0 && old + 1 == longint'(lim_val)) begin
                enter_halt(3);
                small_sync = 0;
            end
            else if (m_budget == 1) enter_halt(4);
            else if (m_budget > 1) begin
                if (s) m_budget = 0;
                else m_budget--;
            end
        end else if (s) begin
            if (!m_halt) m_count = 0;
            m_run = 1; m_halt = 0; m_budget = 0; m_cause = 0;
        end else if (st && sc != 0) begin
            m_run = 1; m_halt = 0; m_budget = sc; m_cause = 0;
        end
    endtask

    task automatic compare_all();
        check("core_clk_en", 64'(core_clk_en), 64'(m_run));
        check("running", 64'(running), 64'(m_run));
        check("halted", 64'(halted), 64'(m_halt));
        check("halt_cause", 64'(halt_cause), 64'(m_cause));
        check("cycle_count", 64'(cycle_count), 64'(sat(m_count, 32)));
        check("done_pulse", 64'(done_pulse), 64'(m_done));
        if (small_sync) begin
            check("small_count", 64'(s_count), 64'(sat(m_count, 4)));
            check("small_running", 64'(s_running), 64'(m_run));
            check("small_clk_en", 64'(s_clk_en), 64'(m_run));
            check("small_halted", 64'(s_halted), 64'(m_halt));
            check("small_cause", 64'(s_cause), 64'(m_cause));
            check("small_done", 64'(s_done), 64'(m_done));
        end
    endtask

    task automatic tick(input bit s, input bit h, input bit st, input int sc, input bit ch);
        start_req = s; halt_req = h; step_req = st; step_count = 8'(sc); core_halt = ch;
        @(posedge clk);
        model_edge(s, h, st, sc, ch);
        #1;
        compare_all();
        start_req = 0; halt_req = 0; step_req = 0; step_count = 0; core_halt = 0;
    endtask

    // Reset asserted between edges: outputs must clear before the next edge.
    task automatic do_reset();
        #2 reset = 1'b1;
        #1 model_reset();
        compare_all();
        #2 reset = 1'b0;
    endtask

    int en_cnt;

    initial begin
        reset = 1'b1;
        start_req = 0; halt_req = 0; step_req = 0; step_count = 0; core_halt = 0;
        lim_val = 0;
        model_reset();
        #11;
        compare_all();
        #1 reset = 1'b0;

        // Scenario 1: start at edge 2, halt at edge 12.
        tick(0, 0, 0, 0, 0);
        tick(1, 0, 0, 0, 0);
        en_cnt = 0;
        if (core_clk_en) en_cnt++;
        for (int i = 3; i <= 11; i++) begin
            tick(0, 0, 0, 0, 0);
            if (core_clk_en) en_cnt++;
        end
        tick(0, 1, 0, 0, 0);
        check("s1_en_cycles", 64'(en_cnt), 64'd10);
        check("s1_count", 64'(cycle_count), 64'd10);
        check("s1_halted", 64'(halted), 64'd1);
        check("s1_cause", 64'(halt_cause), 64'd1);
        check("s1_done", 64'(done_pulse), 64'd1);
        tick(0, 0, 0, 0, 0);
        check("s1_done_once", 64'(done_pulse), 64'd0);

        // Scenario 2: five single steps from IDLE, then a zero-count step is ignored.
        do_reset();
        en_cnt = 0;
        tick(0, 0, 1, 5, 0);
        if (core_clk_en) en_cnt++;
        for (int i = 0; i < 8; i++) begin
            tick(0, 0, 0, 0, 0);
            if (core_clk_en) en_cnt++;
        end
        check("s2_en_cycles", 64'(en_cnt), 64'd5);
        check("s2_cause", 64'(halt_cause), 64'd4);
        check("s2_count", 64'(cycle_count), 64'd5);
        do_reset();
        tick(0, 0, 1, 0, 0);
        check("s2_zero_running", 64'(running), 64'd0);
        check("s2_zero_halted", 64'(halted), 64'd0);

        // Scenario 3: simultaneous host and core halt; resume keeps the count.
        do_reset();
        tick(1, 0, 0, 0, 0);
        for (int i = 0; i < 6; i++) tick(0, 0, 0, 0, 0);
        tick(0, 1, 0, 0, 1);
        check("s3_cause", 64'(halt_cause), 64'd2);
        check("s3_count", 64'(cycle_count), 64'd7);
        tick(1, 0, 0, 0, 0);
        check("s3_resume_running", 64'(running), 64'd1);
        check("s3_resume_cause", 64'(halt_cause), 64'd0);
        tick(0, 0, 0, 0, 0);
        check("s3_resume_count", 64'(cycle_count), 64'd8);

        // Scenario 5: reset mid-run (checked inside do_reset against a cleared model).
        do_reset();

`ifdef CYCLE_LIMIT_EN
        // Scenario 4: watchdog at 100 cycles, then no limit.
        lim_val = 32'd100;
        do_reset();
        tick(1, 0, 0, 0, 0);
        for (int i = 0; i < 110; i++) tick(0, 0, 0, 0, 0);
        check("s4_halted", 64'(halted), 64'd1);
        check("s4_cause", 64'(halt_cause), 64'd3);
        check("s4_count", 64'(cycle_count), 64'd100);
        lim_val = 32'd0;
        do_reset();
        tick(1, 0, 0, 0, 0);
        for (int i = 0; i < 300; i++) tick(0, 0, 0, 0, 0);
        check("s4_nolimit_running", 64'(running), 64'd1);
        check("s4_nolimit_count", 64'(cycle_count), 64'd300);
`endif

        // Scenario 6: narrow counter saturates instead of wrapping.
        do_reset();
        tick(1, 0, 0, 0, 0);
        for (int i = 0; i < 20; i++) tick(0, 0, 0, 0, 0);
        check("s6_small_sat", 64'(s_count), 64'd15);
        check("s6_wide_count", 64'(cycle_count), 64'd20);

        // Randomized request traffic with occasional mid-cycle resets.
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 299) == 0) begin
`ifdef CYCLE_LIMIT_EN
                lim_val = ($urandom_range(0, 3) == 0) ? 32'd0 : 32'($urandom_range(3, 40));
`endif
                do_reset();
            end
            tick($urandom_range(0, 15) == 0, $urandom_range(0, 19) == 0,
                 $urandom_range(0, 11) == 0, int'($urandom_range(0, 5)),
                 $urandom_range(0, 24) == 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
